// File: rtl/mu0_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mu0_pkg                                                                  |
// | Shared opcodes, state encodings, ALU codes and control bundle for MU0.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mu0_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_FETCH = 2'd0;
  localparam state_t S_EXEC  = 2'd1;
  localparam state_t S_HALT  = 2'd2;
  localparam state_t S_PAUSE = 2'd3;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] ALU_PASSY = 2'b00;
  localparam logic [1:0] ALU_ADD   = 2'b01;
  localparam logic [1:0] ALU_INC   = 2'b10;
  localparam logic [1:0] ALU_SUB   = 2'b11;

  typedef struct packed {
    logic       x_sel;
    logic       y_sel;
    logic       addr_sel;
    logic [1:0] alu_fs;
    logic       acc_en;
    logic       pc_en;
    logic       ir_en;
    logic       rd;
    logic       wr;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage
`default_nettype wire

// File: rtl/mu0_step_edge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mu0_step_edge                                                            |
// | Registered rising-edge detector for the single-step request.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mu0_step_edge (
  input  logic Clk,
  input  logic Reset,
  input  logic Step,
  output logic rise
);

  logic r_step_s;
  logic r_step_q;

  // Both samples reset high so a Step held through reset is not seen as an edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_step_s <= 1'b1;
      r_step_q <= 1'b1;
    end else begin
      r_step_s <= Step;
      r_step_q <= r_step_s;
    end
  end

  assign rise = r_step_s & ~r_step_q;

endmodule
`default_nettype wire

// File: rtl/mu0_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mu0_ctrl_fsm                                                             |
// | MU0 fetch/execute control sequencer. Optional MU0_SINGLE_STEP_EN adds    |
// | a Step input and a PAUSE state between instructions.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mu0_ctrl_fsm
  import mu0_pkg::*;
#(
  parameter int OPW    = 4,
  parameter int ALU_FW = 2
) (
  input  logic              Clk,
  input  logic              Reset,
`ifdef MU0_SINGLE_STEP_EN
  input  logic              Step,
`endif
  input  logic [OPW-1:0]    F,
  input  logic              N,
  input  logic              Z,
  output logic              X_sel,
  output logic              Y_sel,
  output logic              Addr_sel,
  output logic [ALU_FW-1:0] ALU_fs,
  output logic              Acc_En,
  output logic              PC_En,
  output logic              IR_En,
  output logic              Rd,
  output logic              Wr,
  output logic              Halted
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

`ifdef MU0_SINGLE_STEP_EN
  localparam state_t c_reset_state = S_PAUSE;
  localparam state_t c_exec_next   = S_PAUSE;
  logic w_resume;

  mu0_step_edge u_step_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .Step  (Step),
    .rise  (w_resume)
  );
`else
  localparam state_t c_reset_state = S_FETCH;
  localparam state_t c_exec_next   = S_FETCH;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= c_reset_state;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: w_next = S_EXEC;
      S_EXEC:  w_next = (F == OP_STP) ? S_HALT : c_exec_next;
      S_HALT:  w_next = S_HALT;
`ifdef MU0_SINGLE_STEP_EN
      S_PAUSE: w_next = w_resume ? S_FETCH : S_PAUSE;
`endif
      default: w_next = c_reset_state;
    endcase
  end

  // Reset gates every output so the async-reset FETCH state does not leak strobes.
  always_comb begin
    w_ctrl = CTRL_IDLE;
    if (!Reset) begin
      case (r_state)
        S_FETCH: begin
          w_ctrl.addr_sel = 1'b0;
          w_ctrl.rd       = 1'b1;
          w_ctrl.ir_en    = 1'b1;
          w_ctrl.x_sel    = 1'b1;
          w_ctrl.alu_fs   = ALU_INC;
          w_ctrl.pc_en    = 1'b1;
        end
        S_EXEC: begin
          case (F)
            OP_LDA: begin
              w_ctrl.addr_sel = 1'b1;
              w_ctrl.rd       = 1'b1;
              w_ctrl.alu_fs   = ALU_PASSY;
              w_ctrl.acc_en   = 1'b1;
            end
            OP_STA: begin
              w_ctrl.addr_sel = 1'b1;
              w_ctrl.wr       = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              w_ctrl.addr_sel = 1'b1;
              w_ctrl.rd       = 1'b1;
              w_ctrl.alu_fs   = (F == OP_SUB) ? ALU_SUB : ALU_ADD;
              w_ctrl.acc_en   = 1'b1;
            end
            OP_JMP, OP_JGE, OP_JNE: begin
              w_ctrl.y_sel  = 1'b1;
              w_ctrl.alu_fs = ALU_PASSY;
              w_ctrl.pc_en  = (F == OP_JMP) | ((F == OP_JGE) & ~N) | ((F == OP_JNE) & ~Z);
            end
            default: w_ctrl = CTRL_IDLE;
          endcase
        end
        S_HALT:  w_ctrl.halted = 1'b1;
        default: w_ctrl = CTRL_IDLE;
      endcase
    end
  end

  assign X_sel    = w_ctrl.x_sel;
  assign Y_sel    = w_ctrl.y_sel;
  assign Addr_sel = w_ctrl.addr_sel;
  assign ALU_fs   = ALU_FW'(w_ctrl.alu_fs);
  assign Acc_En   = w_ctrl.acc_en;
  assign PC_En    = w_ctrl.pc_en;
  assign IR_En    = w_ctrl.ir_en;
  assign Rd       = w_ctrl.rd;
  assign Wr       = w_ctrl.wr;
  assign Halted   = w_ctrl.halted;

endmodule
`default_nettype wire

// File: tb/tb_mu0_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mu0_ctrl_fsm                                                          |
// | Scoreboard bench for mu0_ctrl_fsm against a cycle-level phase model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mu0_ctrl_fsm;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Step = 1'b0;
  logic [3:0] F = 4'h0;
  logic       N = 1'b0;
  logic       Z = 1'b0;
  logic       X_sel, Y_sel, Addr_sel, Acc_En, PC_En, IR_En, Rd, Wr, Halted;
  logic [1:0] ALU_fs;

  mu0_ctrl_fsm dut (
    .Clk      (Clk),
    .Reset    (Reset),
`ifdef MU0_SINGLE_STEP_EN
    .Step     (Step),
`endif
    .F        (F),
    .N        (N),
    .Z        (Z),
    .X_sel    (X_sel),
    .Y_sel    (Y_sel),
    .Addr_sel (Addr_sel),
    .ALU_fs   (ALU_fs),
    .Acc_En   (Acc_En),
    .PC_En    (PC_En),
    .IR_En    (IR_En),
    .Rd       (Rd),
    .Wr       (Wr),
    .Halted   (Halted)
  );

  always #5 Clk = ~Clk;

  typedef enum int {PH_FETCH, PH_EXEC, PH_HALT, PH_PAUSE} phase_t;
  typedef struct {
    logic [10:0] v;
    string       tag;
  } item_t;

  item_t  exp_q[$];
  int     total = 0;
  int     bad = 0;
  phase_t ph = PH_FETCH;
  logic   st_p1 = 1'b1;
  logic   st_p2 = 1'b1;
  logic   cur_step = 1'b0;

`ifdef MU0_SINGLE_STEP_EN
  localparam phase_t c_after_reset = PH_PAUSE;
`else
  localparam phase_t c_after_reset = PH_FETCH;
`endif

  // Vector layout: {X_sel,Y_sel,Addr_sel,ALU_fs[1:0],Acc_En,PC_En,IR_En,Rd,Wr,Halted}
  function automatic logic [10:0] model_out(phase_t p, logic [3:0] f, logic n, logic z, logic rst);
    logic x = 0, y = 0, a = 0, acc = 0, pc = 0, ir = 0, rd = 0, wr = 0, h = 0;
    logic [1:0] fs = 2'b00;
    if (!rst) begin
      if (p == PH_FETCH) begin
        x = 1; fs = 2'b10; pc = 1; ir = 1; rd = 1;
      end else if (p == PH_HALT) begin
        h = 1;
      end else if (p == PH_EXEC) begin
        if (f == 4'd0 || f == 4'd2 || f == 4'd3) begin
          a = 1; rd = 1; acc = 1;
          fs = (f == 4'd0) ? 2'b00 : (f == 4'd2) ? 2'b01 : 2'b11;
        end else if (f == 4'd1) begin
          a = 1; wr = 1;
        end else if (f >= 4'd4 && f <= 4'd6) begin
          y = 1;
          pc = (f == 4'd4) ? 1'b1 : (f == 4'd5) ? !n : !z;
        end
      end
    end
    return {x, y, a, fs, acc, pc, ir, rd, wr, h};
  endfunction

  task automatic drive(input logic rst, input logic [3:0] f, input logic n, input logic z,
                       input logic st, input string tag);
    item_t  it;
    logic   rise;
    @(posedge Clk);
    #1;
    Reset = rst; F = f; N = n; Z = z; Step = st;
    it.v   = model_out(ph, f, n, z, rst);
    it.tag = tag;
    exp_q.push_back(it);
`ifdef MU0_SINGLE_STEP_EN
    rise = st_p1 & ~st_p2;
`else
    rise = 1'b0;
`endif
    if (rst) ph = c_after_reset;
    else case (ph)
      PH_FETCH: ph = PH_EXEC;
      PH_EXEC:  ph = (f == 4'd7) ? PH_HALT : c_after_reset;
      PH_HALT:  ph = PH_HALT;
      PH_PAUSE: ph = rise ? PH_FETCH : PH_PAUSE;
      default:  ph = c_after_reset;
    endcase
    if (rst) begin
      st_p1 = 1'b1; st_p2 = 1'b1;
    end else begin
      st_p2 = st_p1; st_p1 = st;
    end
  endtask

  task automatic do_reset(input int cycles);
    for (int k = 0; k < cycles; k++)
      drive(1'b1, 4'($urandom), 1'($urandom), 1'($urandom), cur_step, "reset");
  endtask

  task automatic instr(input logic [3:0] f, input logic n, input logic z, input string tag);
    if (ph == PH_PAUSE) begin
      cur_step = 1'b0;
      drive(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), cur_step, "pause");
      cur_step = 1'b1;
      for (int k = 0; k < 6 && ph != PH_FETCH; k++)
        drive(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), cur_step, "pause_step");
    end
    drive(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), cur_step, "fetch");
    drive(1'b0, f, n, z, cur_step, tag);
  endtask

  task automatic hold_halt();
    for (int k = 0; k < 20; k++)
      drive(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), cur_step, "halt");
    do_reset(2);
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      item_t       it;
      logic [10:0] act;
      it  = exp_q.pop_front();
      act = {X_sel, Y_sel, Addr_sel, ALU_fs, Acc_En, PC_En, IR_En, Rd, Wr, Halted};
      total++;
      if (act !== it.v || (Rd && Wr) || (Acc_En && IR_En)) begin
        bad++;
        $display("FAIL %s @%0t: got %b want %b", it.tag, $time, act, it.v);
      end
    end
  end

  initial begin
    do_reset(3);
`ifdef MU0_SINGLE_STEP_EN
    cur_step = 1'b1;
    do_reset(3);
    for (int k = 0; k < 5; k++)
      drive(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), cur_step, "step_held");
`endif
    instr(4'd0, 1'b0, 1'b0, "lda");
    instr(4'd2, 1'b1, 1'b0, "add");
    instr(4'd3, 1'b0, 1'b1, "sub");
    instr(4'd1, 1'b0, 1'b0, "sta");
    instr(4'd4, 1'b1, 1'b1, "jmp");
    instr(4'd5, 1'b1, 1'b0, "jge_n1");
    instr(4'd5, 1'b0, 1'b1, "jge_n0");
    instr(4'd6, 1'b0, 1'b1, "jne_z1");
    instr(4'd6, 1'b1, 1'b0, "jne_z0");
    instr(4'd9, 1'b1, 1'b1, "nop9");
    instr(4'd7, 1'b0, 1'b0, "stp");
    hold_halt();
    for (int i = 0; i < 150; i++) begin
      logic [3:0] f;
      f = 4'($urandom_range(0, 15));
      if (f == 4'd7 && $urandom_range(0, 3) != 0) f = 4'd8;
      if (ph == PH_FETCH && $urandom_range(0, 24) == 0) begin
        drive(1'b0, 4'($urandom), 1'($urandom), 1'($urandom), cur_step, "fetch_abort");
        do_reset(int'($urandom_range(1, 2)));
      end
      instr(f, 1'($urandom), 1'($urandom), "rand_exec");
      if (ph == PH_HALT) hold_halt();
      else if ($urandom_range(0, 19) == 0) do_reset(int'($urandom_range(1, 3)));
    end
    repeat (3) @(posedge Clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
